// File: rtl/bram_writeback_ctrl_if.sv
// Writeback datapath bundle: upstream result stream in, BRAM Port A write out.
interface bram_writeback_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;

    // Producer / BRAM-observer side
    modport master (
        output in_valid, in_data,
        input  in_ready, bram_en, bram_we, bram_addr, bram_din
    );

    // Writeback controller side
    modport slave (
        input  in_valid, in_data,
        output in_ready, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_writeback_ctrl.sv
// Tile writeback controller: streams TILE_WORDS result words into a BRAM
// region selected per tile, with a persistent or ping-pong write pointer.
module bram_writeback_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned REGION_WORDS = 4096,
    parameter int unsigned TILE_WORDS   = 768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_wb,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Buffer_Select,
    input  logic                  Double_buffering,
    bram_writeback_ctrl_if.slave  bus,
    output logic                  wb_done,
    output logic                  busy
);
    localparam int unsigned HALF_WORDS = REGION_WORDS / 2;
    localparam int unsigned PTR_W      = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
    localparam int unsigned CNT_W      = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) + 1 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic             pp;
    logic [CNT_W-1:0] beat_cnt;
    logic [2:0]       sel_q;
    logic             db_q;

    logic [ADDR_WIDTH-1:0] addr_c;
    logic [PTR_W-1:0]      ptr_limit_c;
    logic [PTR_W-1:0]      ptr_nxt_c;
    logic                  accept_c;
    logic                  last_beat_c;

    // Address of the current beat and next pointer value (wrap at region or half-region)
    always_comb begin
        addr_c      = ADDR_WIDTH'(sel_q) * ADDR_WIDTH'(REGION_WORDS)
                    + ((pp && db_q) ? ADDR_WIDTH'(HALF_WORDS) : ADDR_WIDTH'(0))
                    + ADDR_WIDTH'(wr_ptr);
        ptr_limit_c = db_q ? PTR_W'(HALF_WORDS - 1) : PTR_W'(REGION_WORDS - 1);
        ptr_nxt_c   = (wr_ptr >= ptr_limit_c) ? PTR_W'(0) : wr_ptr + PTR_W'(1);
        accept_c    = bus.in_valid && bus.in_ready;
        last_beat_c = (beat_cnt == CNT_W'(TILE_WORDS - 1));
    end

    // Control FSM, pointer bookkeeping and registered BRAM/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            pp            <= 1'b0;
            beat_cnt      <= '0;
            sel_q         <= '0;
            db_q          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.bram_en   <= 1'b0;
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
            wb_done       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.bram_en <= 1'b0;
            bus.bram_we <= 1'b0;
            wb_done     <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear takes effect before a coincident start
                    if (reset_addr_counter) begin
                        wr_ptr <= '0;
                        pp     <= 1'b0;
                    end
                    if (start_wb) begin
                        sel_q        <= Buffer_Select;
                        db_q         <= Double_buffering;
                        beat_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept_c) begin
                        bus.bram_en   <= 1'b1;
                        bus.bram_we   <= 1'b1;
                        bus.bram_addr <= addr_c;
                        bus.bram_din  <= DATA_WIDTH'(bus.in_data);
                        beat_cnt      <= beat_cnt + CNT_W'(1);
                        if (last_beat_c) begin
                            bus.in_ready <= 1'b0;
                            wb_done      <= 1'b1;
                            state        <= DONE;
                            if (db_q) begin
                                pp     <= ~pp;
                                wr_ptr <= '0;
                            end else begin
                                wr_ptr <= ptr_nxt_c;
                            end
                        end else begin
                            wr_ptr <= ptr_nxt_c;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule
